// File: rtl/dvi_fetch_sched.sv
// Read scheduler for the DVI line buffer: one memory burst per ram_ask, packing
// 64-bit beats into a 6144-bit pixel block while walking the frame address.
module dvi_fetch_sched #(
  parameter int unsigned       ADDR_W           = 27,
  parameter logic [ADDR_W-1:0] BASE_ADDR        = '0,
  parameter int unsigned       BLOCKS_PER_FRAME = 3072,
  parameter int unsigned       BLOCK_BYTES      = 768,
  parameter int unsigned       BEATS            = 96
) (
  input  logic              clk125,
  input  logic              reset,
  input  logic              enable,
  input  logic              new_frame,
  input  logic              ram_ask,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [6:0]        mem_cmd_len,
  input  logic              mem_rd_valid,
  input  logic [63:0]       mem_rd_data,
  output logic [6143:0]     pixel_data,
  output logic              pixel_valid,
  output logic [11:0]       block_idx,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned PixW = 6144;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e            state_q, state_d;
  logic              ask_pend_q, frame_pend_q, overrun_q, pixel_valid_q;
  logic [6:0]        beat_cnt_q;
  logic [11:0]       block_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PixW-1:0]   asm_q, pixel_q;
  logic [PixW-1:0]   asm_next;
  logic              go, cmd_fire, beat, last_beat;

  assign asm_next = {asm_q[PixW-65:0], mem_rd_data};

  always_comb begin
    state_d   = state_q;
    go        = 1'b0;
    cmd_fire  = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ask_pend_q && enable) begin
          go      = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (mem_cmd_ready) begin
          cmd_fire = 1'b1;
          state_d  = StData;
        end
      end
      StData: begin
        if (mem_rd_valid) begin
          beat = 1'b1;
          if (beat_cnt_q == 7'(BEATS - 1)) begin
            last_beat = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (reset) begin
      state_q       <= StIdle;
      ask_pend_q    <= 1'b0;
      frame_pend_q  <= 1'b0;
      overrun_q     <= 1'b0;
      pixel_valid_q <= 1'b0;
      beat_cnt_q    <= '0;
      block_q       <= '0;
      addr_q        <= BASE_ADDR;
      pixel_q       <= '0;
    end else begin
      state_q       <= state_d;
      pixel_valid_q <= last_beat;

      // A new ask wins over the clear from the IDLE->CMD decision on the same edge.
      if (ram_ask) begin
        ask_pend_q <= 1'b1;
        if (ask_pend_q && !go) overrun_q <= 1'b1;
      end else if (go) begin
        ask_pend_q <= 1'b0;
      end

      if (cmd_fire)  beat_cnt_q <= '0;
      else if (beat) beat_cnt_q <= beat_cnt_q + 7'd1;

      if (beat) asm_q <= asm_next;

      if (last_beat) begin
        pixel_q      <= asm_next;
        frame_pend_q <= 1'b0;
        if (frame_pend_q || new_frame || block_q == 12'(BLOCKS_PER_FRAME - 1)) begin
          block_q <= '0;
          addr_q  <= BASE_ADDR;
        end else begin
          block_q <= block_q + 12'd1;
          addr_q  <= addr_q + ADDR_W'(BLOCK_BYTES);
        end
      end else if (new_frame) begin
        if (state_q == StIdle) begin
          block_q <= '0;
          addr_q  <= BASE_ADDR;
        end else begin
          frame_pend_q <= 1'b1;
        end
      end
    end
  end

  assign mem_cmd_valid = (state_q == StCmd);
  assign busy          = (state_q != StIdle);
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_len   = 7'(BEATS);
  assign pixel_data    = pixel_q;
  assign pixel_valid   = pixel_valid_q;
  assign block_idx     = block_q;
  assign overrun       = overrun_q;

endmodule
